// File: rtl/axilite_sram_peripheral_if.sv
// axilite_sram_peripheral_if: AXI4-Lite AW/W/B/AR/R bundle between a master and the SRAM peripheral.
interface axilite_sram_peripheral_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
);
   logic [ADDR_W-1:0]   awaddr;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;
   logic [ADDR_W-1:0]   araddr;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid;
   logic                rready;
   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axilite_sram_peripheral.sv
// axilite_sram_peripheral: AXI4-Lite slave over a byte-strobed register array.
// Define AXILITE_SRAM_PERIPHERAL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of wrapping.
module axilite_sram_peripheral #(
   parameter int AXILITE_ADDR_WIDTH = 64,
   parameter int AXILITE_DATA_WIDTH = 512,
   parameter int DEPTH              = 64
) (
   input logic clk,
   input logic rst,
   axilite_sram_peripheral_if.slave s_axi
);
   localparam int STRB_W = AXILITE_DATA_WIDTH / 8;
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int LSB    = $clog2(STRB_W);

   logic [AXILITE_ADDR_WIDTH-1:0] awaddr_q;
   logic                          aw_full_q;
   logic [AXILITE_DATA_WIDTH-1:0] wdata_q;
   logic [STRB_W-1:0]             wstrb_q;
   logic                          w_full_q;
   logic                          bvalid_q;
   logic [1:0]                    bresp_q;
   logic                          rvalid_q;
   logic [1:0]                    rresp_q;
   logic [AXILITE_DATA_WIDTH-1:0] rdata_q;
   logic [AXILITE_DATA_WIDTH-1:0] mem_q [DEPTH];

   logic aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
   logic [IDX_W-1:0] widx, ridx;
   logic unused_addr;

   assign s_axi.awready = !aw_full_q;
   assign s_axi.wready  = !w_full_q;
   assign s_axi.arready = !rvalid_q || s_axi.rready;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;

   assign aw_hs  = s_axi.awvalid && !aw_full_q;
   assign w_hs   = s_axi.wvalid && !w_full_q;
   assign ar_hs  = s_axi.arvalid && s_axi.arready;
   assign commit = aw_full_q && w_full_q && (!bvalid_q || s_axi.bready);
   assign widx   = awaddr_q[LSB +: IDX_W];
   assign ridx   = s_axi.araddr[LSB +: IDX_W];
   // Sub-word and (when wrapping) upper address bits are intentionally ignored.
   assign unused_addr = ^{awaddr_q, s_axi.araddr};

`ifdef AXILITE_SRAM_PERIPHERAL_SLVERR_EN
   assign w_ok = (awaddr_q >> LSB) < AXILITE_ADDR_WIDTH'(DEPTH);
   assign r_ok = (s_axi.araddr >> LSB) < AXILITE_ADDR_WIDTH'(DEPTH);
`else
   assign w_ok = 1'b1;
   assign r_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         awaddr_q  <= '0;
         aw_full_q <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         w_full_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (aw_hs) begin
            aw_full_q <= 1'b1;
            awaddr_q  <= s_axi.awaddr;
         end
         if (w_hs) begin
            w_full_q <= 1'b1;
            wdata_q  <= s_axi.wdata;
            wstrb_q  <= s_axi.wstrb;
         end
         if (commit) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= w_ok ? 2'b00 : 2'b10;
            for (int i = 0; i < STRB_W; i++)
               if (w_ok && wstrb_q[i]) mem_q[widx][8*i +: 8] <= wdata_q[8*i +: 8];
         end else if (bvalid_q && s_axi.bready) begin
            bvalid_q <= 1'b0;
         end
         // The read samples mem_q before this edge's commit lands, so it returns old data.
         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= r_ok ? 2'b00 : 2'b10;
            rdata_q  <= r_ok ? mem_q[ridx] : '0;
         end else if (rvalid_q && s_axi.rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axilite_sram_peripheral.sv
// tb_axilite_sram_peripheral: directed vector table plus hand-written corner sequences.
module tb_axilite_sram_peripheral;
   localparam int AW = 32, DW = 64, DEPTH = 16;
`ifdef AXILITE_SRAM_PERIPHERAL_SLVERR_EN
   localparam bit SLVERR = 1'b1;
`else
   localparam bit SLVERR = 1'b0;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      logic [1:0]  bresp;
      logic [63:0] rexp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axilite_sram_peripheral_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   axilite_sram_peripheral #(
      .AXILITE_ADDR_WIDTH(AW), .AXILITE_DATA_WIDTH(DW), .DEPTH(DEPTH)
   ) dut (.clk(clk), .rst(rst), .s_axi(bus));

   int n_chk = 0, n_fail = 0;
   vec_t vecs [6];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            output logic [1:0] resp, output int lat);
      int t;
      bit aw_go, w_go;
      bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
      t = 0;
      while ((bus.awvalid || bus.wvalid) && t < 20) begin
         aw_go = bus.awvalid && bus.awready;
         w_go  = bus.wvalid && bus.wready;
         tick;
         if (aw_go) bus.awvalid = 1'b0;
         if (w_go) bus.wvalid = 1'b0;
         t++;
      end
      chk("write_accept", 64'(t < 20), 64'd1);
      lat = 0;
      while (!bus.bvalid && lat < 20) begin
         tick;
         lat++;
      end
      resp = bus.bresp;
      tick;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [63:0] d, output logic [1:0] r);
      int t;
      bus.araddr = a; bus.rready = 1'b1; bus.arvalid = 1'b1;
      #1;
      t = 0;
      while (!bus.arready && t < 20) begin
         tick;
         t++;
      end
      tick;
      bus.arvalid = 1'b0;
      chk("read_latency", 64'(bus.rvalid), 64'd1);
      d = bus.rdata;
      r = bus.rresp;
      tick;
   endtask

   task automatic chk_reset;
      chk("rst_awready", 64'(bus.awready), 64'd1);
      chk("rst_wready", 64'(bus.wready), 64'd1);
      chk("rst_arready", 64'(bus.arready), 64'd1);
      chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
      chk("rst_bresp", 64'(bus.bresp), 64'd0);
      chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
      chk("rst_rresp", 64'(bus.rresp), 64'd0);
      chk("rst_rdata", bus.rdata, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [1:0]  resp;
      logic [63:0] rd;
      int          lat;
      vecs[0] = '{32'h00, 64'hA5A5A5A5A5A5A5A5, 8'hFF, 2'b00, 64'hA5A5A5A5A5A5A5A5};
      vecs[1] = '{32'h08, 64'h1122334455667788, 8'h0F, 2'b00, 64'h0000000055667788};
      vecs[2] = '{32'h08, 64'hFFFFFFFFFFFFFFFF, 8'h00, 2'b00, 64'h0000000055667788};
      vecs[3] = '{32'h0F, 64'hAABBCCDDEEFF0011, 8'hF0, 2'b00, 64'hAABBCCDD55667788};
      vecs[4] = '{32'h78, 64'hDEADBEEFCAFEF00D, 8'hFF, 2'b00, 64'hDEADBEEFCAFEF00D};
      vecs[5] = '{32'h10, 64'h0123456789ABCDEF, 8'h81, 2'b00, 64'h01000000000000EF};
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b1; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
      repeat (2) tick;
      chk_reset;
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
         chk($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].bresp));
         chk($sformatf("vec%0d_blat", i), 64'(lat), 64'd1);
         axi_read(vecs[i].addr, rd, resp);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rexp);
         chk($sformatf("vec%0d_rresp", i), 64'(resp), 64'd0);
      end

      // W arrives three cycles ahead of AW, lane 0 only, on zeroed word 4.
      bus.wdata = 64'hCCCCCCCCCCCCCC5A; bus.wstrb = 8'h01; bus.wvalid = 1'b1;
      tick;
      bus.wvalid = 1'b0;
      chk("early_w_wready_low", 64'(bus.wready), 64'd0);
      repeat (2) tick;
      chk("early_w_wready_held", 64'(bus.wready), 64'd0);
      bus.awaddr = 32'h20; bus.awvalid = 1'b1;
      tick;
      bus.awvalid = 1'b0;
      chk("early_w_no_b_yet", 64'(bus.bvalid), 64'd0);
      tick;
      chk("early_w_bvalid", 64'(bus.bvalid), 64'd1);
      chk("early_w_wready_back", 64'(bus.wready), 64'd1);
      chk("early_w_bresp", 64'(bus.bresp), 64'd0);
      tick;
      axi_read(32'h20, rd, resp);
      chk("early_w_rdata", rd, 64'h000000000000005A);

      // Two writes queued behind a B channel held off for five cycles.
      bus.bready = 1'b0;
      bus.awaddr = 32'h28; bus.wdata = 64'h5555555555555555; bus.wstrb = 8'hFF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      tick;
      bus.awaddr = 32'h30; bus.wdata = 64'h6666666666666666;
      tick;
      chk("bp_first_bvalid", 64'(bus.bvalid), 64'd1);
      chk("bp_awready_free", 64'(bus.awready), 64'd1);
      tick;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      repeat (3) tick;
      chk("bp_awready_stall", 64'(bus.awready), 64'd0);
      chk("bp_wready_stall", 64'(bus.wready), 64'd0);
      chk("bp_bvalid_held", 64'(bus.bvalid), 64'd1);
      chk("bp_bresp_stable", 64'(bus.bresp), 64'd0);
      bus.bready = 1'b1;
      tick;
      chk("bp_second_bvalid_no_gap", 64'(bus.bvalid), 64'd1);
      tick;
      chk("bp_bvalid_drained", 64'(bus.bvalid), 64'd0);
      axi_read(32'h28, rd, resp);
      chk("bp_word5", rd, 64'h5555555555555555);
      axi_read(32'h30, rd, resp);
      chk("bp_word6", rd, 64'h6666666666666666);

      // Out-of-range write and read.
      axi_write(32'h80, 64'h9999999999999999, 8'hFF, resp, lat);
      chk("oor_bresp", 64'(resp), SLVERR ? 64'd2 : 64'd0);
      axi_read(32'h00, rd, resp);
      chk("oor_word0", rd, SLVERR ? 64'hA5A5A5A5A5A5A5A5 : 64'h9999999999999999);
      axi_read(32'h80, rd, resp);
      chk("oor_rdata", rd, SLVERR ? 64'd0 : 64'h9999999999999999);
      chk("oor_rresp", 64'(resp), SLVERR ? 64'd2 : 64'd0);

      // Read and commit to word 3 at the same edge.
      axi_write(32'h18, 64'h3333333333333333, 8'hFF, resp, lat);
      bus.awaddr = 32'h18; bus.wdata = 64'h4444444444444444; bus.wstrb = 8'hFF;
      bus.awvalid = 1'b1; bus.wvalid = 1'b1;
      tick;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      bus.araddr = 32'h18; bus.arvalid = 1'b1;
      tick;
      bus.arvalid = 1'b0;
      chk("raw_rvalid", 64'(bus.rvalid), 64'd1);
      chk("raw_old_data", bus.rdata, 64'h3333333333333333);
      chk("raw_bvalid", 64'(bus.bvalid), 64'd1);
      tick;
      axi_read(32'h18, rd, resp);
      chk("raw_new_data", rd, 64'h4444444444444444);

      // Reset while an AW is buffered and a read response is pending.
      bus.rready = 1'b0;
      bus.awaddr = 32'h00; bus.awvalid = 1'b1;
      bus.araddr = 32'h08; bus.arvalid = 1'b1;
      tick;
      bus.awvalid = 1'b0; bus.arvalid = 1'b0;
      chk("pre_rst_aw_full", 64'(bus.awready), 64'd0);
      chk("pre_rst_rvalid", 64'(bus.rvalid), 64'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk_reset;
      axi_read(32'h08, rd, resp);
      chk("post_rst_word1", rd, 64'd0);
      axi_read(32'h18, rd, resp);
      chk("post_rst_word3", rd, 64'd0);
      axi_read(32'h78, rd, resp);
      chk("post_rst_word15", rd, 64'd0);
      bus.wdata = 64'h1; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
      tick;
      bus.wvalid = 1'b0;
      repeat (2) tick;
      chk("post_rst_aw_discarded", 64'(bus.bvalid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
